// File: rtl/shift_register.sv
// Self-contained serial transmitter. It loops forever over a 4-byte ROM
// (0x55, 0xA5, 0x0F, 0xC3) and sends each byte as one frame: a start bit (0),
// 8 data bits LSB first, a stop bit (1), then IDLE_BITS idle bits (1).
// Every bit is held for CLKS_PER_BIT clocks, and serialOut comes straight from a flop.
//
// Timing model: state/bit_cnt/cyc_cnt describe the bit that the *next* edge
// puts on serialOut. Reset leaves the machine armed in START with the line
// high. The first edge with rst low therefore drives the start bit.
`timescale 1ns/1ps

module shift_register #(
    parameter int CLKS_PER_BIT = 1,   // 1..65535 clocks per serial bit
    parameter int IDLE_BITS    = 2    // 0..15 idle bit periods after stop
) (
    input  logic clk,
    input  logic rst,
    output logic serialOut
);

    // The cycle counter only has to reach CLKS_PER_BIT-1. It keeps at least one bit
    // so the CLKS_PER_BIT=1 case still has a legal vector width.
    localparam int               CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]    CYC_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       IDLE_LAST = (IDLE_BITS > 0) ? 4'(IDLE_BITS - 1) : 4'd0;

    typedef enum logic [1:0] {
        START,
        DATA,
        STOP,
        IDLE
    } state_t;

    state_t          state;
    logic [1:0]      rom_idx;
    logic [3:0]      bit_cnt;     // data bit 0..7, or idle bit 0..IDLE_BITS-1
    logic [CW-1:0]   cyc_cnt;     // clock within the current bit period
    logic [7:0]      shift_reg;
    logic            bit_done;

    // NOTE: the payload is a constant lookup, not a storage array, so it needs
    // no reset and costs nothing to initialise.
    function automatic logic [7:0] rom_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    rom_byte = 8'h55;
            2'd1:    rom_byte = 8'hA5;
            2'd2:    rom_byte = 8'h0F;
            default: rom_byte = 8'hC3;
        endcase
    endfunction

    // Last clock of the current bit period: the edge that advances to the next bit.
    assign bit_done = (cyc_cnt == CYC_LAST);

    // Frame sequencer, shift register and registered serial output.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses non-blocking assignment. All branches then
        // see the pre-edge values, as real flops do, whatever the statement order.
        if (rst) begin
            serialOut <= 1'b1;
            state     <= START;
            rom_idx   <= 2'd0;
            bit_cnt   <= 4'd0;
            cyc_cnt   <= '0;
            shift_reg <= 8'h00;
        end else begin
            cyc_cnt <= bit_done ? '0 : cyc_cnt + 1'b1;

            case (state)
                START: begin
                    serialOut <= 1'b0;
                    shift_reg <= rom_byte(rom_idx);
                    if (bit_done) begin
                        state <= DATA;
                    end
                end

                DATA: begin
                    serialOut <= shift_reg[0];
                    if (bit_done) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                STOP: begin
                    serialOut <= 1'b1;
                    if (bit_done) begin
                        rom_idx <= rom_idx + 1'b1;   // wraps 3 -> 0 naturally
                        state   <= (IDLE_BITS == 0) ? START : IDLE;
                    end
                end

                IDLE: begin
                    serialOut <= 1'b1;
                    if (bit_done) begin
                        if (bit_cnt == IDLE_LAST) begin
                            bit_cnt <= 4'd0;
                            state   <= START;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    serialOut <= 1'b1;
                    state     <= START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_register.sv
// Bench for shift_register. It drives a default-parameter instance
// (1 clk/bit, 2 idle bits) and a slow instance (4 clk/bit, no idle bits).
// Frames are written below as 12-bit (or 10-bit) constants, sent MSB first:
// {start, d0..d7, stop, idle, idle}.
`timescale 1ns/1ps

module tb_shift_register;

    localparam logic [11:0] FRAME_55 = 12'h557;  // 0 1010 1010 111
    localparam logic [11:0] FRAME_A5 = 12'h52F;  // 0 1010 0101 111
    localparam logic [11:0] FRAME_0F = 12'h787;  // 0 1111 0000 111
    localparam logic [11:0] FRAME_C3 = 12'h61F;  // 0 1100 0011 111
    localparam logic [9:0]  SLOW_55  = 10'b0101010101;
    localparam logic [9:0]  SLOW_A5  = 10'b0101001011;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst4 = 1'b1;
    logic ser;
    logic ser4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic  rst;
        logic  exp;
        string name;
    } vec_t;

    vec_t vecs[$];

    always #12.5 clk = ~clk;

    shift_register u_dut (
        .clk       (clk),
        .rst       (rst),
        .serialOut (ser)
    );

    shift_register #(
        .CLKS_PER_BIT (4),
        .IDLE_BITS    (0)
    ) u_dut4 (
        .clk       (clk),
        .rst       (rst4),
        .serialOut (ser4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive the resets mid-cycle, let one rising edge pass, then sample on the falling edge.
    task automatic step(input logic r, input logic r4);
        rst  = r;
        rst4 = r4;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add_frame(input logic [11:0] f, input string nm);
        for (int i = 0; i < 12; i++) begin
            vecs.push_back('{rst: 1'b0, exp: f[11-i], name: nm});
        end
    endtask

    // Run n cycles of frame f. glitch_at >= 0 puts a rst pulse between two edges.
    task automatic run_frame(input logic [11:0] f, input int n, input string nm, input int glitch_at);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1);
            check($sformatf("%s[%0d]", nm, i), 32'(ser), 32'(f[11-i]));
            if (i == glitch_at) begin
                #2 rst = 1'b1;
                #3 rst = 1'b0;
            end
        end
    endtask

    initial begin
        logic [7:0] exp_bytes [4];
        logic [9:0] slow;
        int         rx_state;
        int         rx_cnt;
        logic [7:0] rx_byte;
        int         frame_err;
        int         nbytes;

        exp_bytes = '{8'h55, 8'hA5, 8'h0F, 8'hC3};

        // Reset window: 100 ns = 4 rising edges with rst high.
        for (int i = 0; i < 4; i++) begin
            vecs.push_back('{rst: 1'b1, exp: 1'b1, name: "reset"});
        end
        add_frame(FRAME_55, "f1_55");
        add_frame(FRAME_A5, "f2_A5");
        add_frame(FRAME_0F, "f3_0F");
        add_frame(FRAME_C3, "f4_C3");
        add_frame(FRAME_55, "f5_wrap55");

        foreach (vecs[i]) begin
            step(vecs[i].rst, 1'b1);
            check($sformatf("%s_cyc%0d", vecs[i].name, i), 32'(ser), 32'(vecs[i].exp));
        end

        // Mid-frame abort. Restart cleanly, send one full frame, then stop 6 cycles
        // into frame 2, where serialOut carries data bit 4.
        step(1'b1, 1'b1);
        check("rst_pre", 32'(ser), 32'd1);
        run_frame(FRAME_55, 12, "abort_f1", -1);
        run_frame(FRAME_A5, 6, "abort_f2", -1);
        step(1'b1, 1'b1);
        check("abort_line_high", 32'(ser), 32'd1);
        // The restart must come from ROM[0]. A short rst pulse between edges is ignored.
        run_frame(FRAME_55, 12, "restart_55", 3);
        run_frame(FRAME_A5, 12, "restart_A5", -1);

        // Receiver sampling one bit per clock over 1000 cycles.
        step(1'b1, 1'b1);
        rx_state  = 0;
        rx_cnt    = 0;
        rx_byte   = 8'h00;
        frame_err = 0;
        nbytes    = 0;
        for (int c = 0; c < 1000; c++) begin
            step(1'b0, 1'b1);
            case (rx_state)
                0: if (ser == 1'b0) begin
                    rx_state = 1;
                    rx_cnt   = 0;
                end
                1: begin
                    rx_byte[rx_cnt] = ser;
                    rx_cnt++;
                    if (rx_cnt == 8) rx_state = 2;
                end
                default: begin
                    if (ser !== 1'b1) begin
                        frame_err++;
                    end else begin
                        check($sformatf("rx_byte%0d", nbytes), 32'(rx_byte), 32'(exp_bytes[nbytes % 4]));
                        nbytes++;
                    end
                    rx_state = 0;
                end
            endcase
        end
        check("rx_framing_errors", 32'(frame_err), 32'd0);
        check("rx_byte_count", 32'(nbytes), 32'd83);

        // Slow instance: every bit lasts 4 clocks and a frame is 40 clocks.
        step(1'b1, 1'b1);
        check("slow_reset", 32'(ser4), 32'd1);
        for (int c = 0; c < 80; c++) begin
            step(1'b1, 1'b0);
            slow = (c < 40) ? SLOW_55 : SLOW_A5;
            check($sformatf("slow_cyc%0d", c), 32'(ser4), 32'(slow[9 - (c % 40) / 4]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
